// File: rtl/aes_avalon_pkg.sv
// rtl/aes_avalon_pkg.sv - shared FSM state type and register map for the AES Avalon slave
// Contents: aes_state_e (controller states), ADDR_* word addresses of the 16-entry register map.
package aes_avalon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } aes_state_e;

    localparam int NUM_REGS      = 16;
    localparam int ADDR_KEY0     = 0;
    localparam int ADDR_MSG_ENC0 = 4;
    localparam int ADDR_MSG_DEC0 = 8;
    localparam int ADDR_SCRATCH0 = 12;
    localparam int ADDR_START    = 14;
    localparam int ADDR_DONE     = 15;

endpackage

// File: rtl/avl_reg32.sv
// rtl/avl_reg32.sv - 32-bit register with per-byte write enables and async active-low clear
// Ports: clk, rst_n (async clear), load (write strobe), byte_en[3:0] (lane i = bits 8i+7:8i),
//        wdata[31:0] (write data), q[31:0] (register value).
module avl_reg32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    q[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/aes_avalon_interface.sv
// rtl/aes_avalon_interface.sv - Avalon-MM register slave that feeds and sequences an AES decryption core
// Ports: CLK, RESET_N (async active-low); AVL_CS/READ/WRITE/ADDR/BYTE_EN/WRITEDATA/READDATA (slave bus);
//        AES_KEY, AES_MSG_ENC, AES_START (to core); AES_DONE, AES_MSG_DEC (from core);
//        EXPORT_DATA ({reg0[31:16], reg3[15:0]} for the hex display).
module aes_avalon_interface
    import aes_avalon_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         AVL_CS,
    input  logic         AVL_READ,
    input  logic         AVL_WRITE,
    input  logic [3:0]   AVL_ADDR,
    input  logic [3:0]   AVL_BYTE_EN,
    input  logic [31:0]  AVL_WRITEDATA,
    output logic [31:0]  AVL_READDATA,
    output logic [127:0] AES_KEY,
    output logic [127:0] AES_MSG_ENC,
    output logic         AES_START,
    input  logic         AES_DONE,
    input  logic [127:0] AES_MSG_DEC,
    output logic [31:0]  EXPORT_DATA
);

    aes_state_e  state_q, state_d;
    logic        wr_en;
    logic        start_q;
    logic        done_q;
    logic [31:0] dec_q [4];
    logic [31:0] reg_q [NUM_REGS];

    assign wr_en = AVL_CS & AVL_WRITE;

    // Register file: KEY/MSG_ENC are writable only in IDLE so the core operands
    // stay frozen for the whole operation (RUN through DONE).
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i < ADDR_MSG_DEC0) begin : g_operand
            logic load;
            assign load = wr_en && (AVL_ADDR == 4'(i)) && (state_q == ST_IDLE);
            avl_reg32 u_reg (
                .clk     (CLK),
                .rst_n   (RESET_N),
                .load    (load),
                .byte_en (AVL_BYTE_EN),
                .wdata   (AVL_WRITEDATA),
                .q       (reg_q[i])
            );
        end else if (i < ADDR_SCRATCH0) begin : g_result
            assign reg_q[i] = dec_q[i - ADDR_MSG_DEC0];
        end else if (i < ADDR_START) begin : g_scratch
            logic load;
            assign load = wr_en && (AVL_ADDR == 4'(i));
            avl_reg32 u_reg (
                .clk     (CLK),
                .rst_n   (RESET_N),
                .load    (load),
                .byte_en (AVL_BYTE_EN),
                .wdata   (AVL_WRITEDATA),
                .q       (reg_q[i])
            );
        end else if (i == ADDR_START) begin : g_start
            assign reg_q[i] = {31'b0, start_q};
        end else begin : g_done
            assign reg_q[i] = {31'b0, done_q};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            start_q <= 1'b0;
        end else if (wr_en && (AVL_ADDR == 4'(ADDR_START)) && AVL_BYTE_EN[0]) begin
            start_q <= AVL_WRITEDATA[0];
        end
    end

    // Result words are captured on the edge that leaves CAPTURE; word 0 is the MSW.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int j = 0; j < 4; j++) begin
                dec_q[j] <= '0;
            end
        end else if (state_q == ST_CAPTURE) begin
            for (int j = 0; j < 4; j++) begin
                dec_q[j] <= AES_MSG_DEC[127 - 32*j -: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            done_q <= 1'b0;
        end else if (state_q == ST_CAPTURE) begin
            done_q <= 1'b1;
        end else if ((state_q == ST_DONE) && !start_q) begin
            done_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE waits for software to drop START, so a lingering START=1 cannot
    // retrigger; a new run needs an explicit 0 then 1.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_q)  state_d = ST_RUN;
            ST_RUN:     if (AES_DONE) state_d = ST_CAPTURE;
            ST_CAPTURE:               state_d = ST_DONE;
            ST_DONE:    if (!start_q) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    assign AES_START    = (state_q != ST_IDLE);
    assign AES_KEY      = {reg_q[ADDR_KEY0], reg_q[ADDR_KEY0+1], reg_q[ADDR_KEY0+2], reg_q[ADDR_KEY0+3]};
    assign AES_MSG_ENC  = {reg_q[ADDR_MSG_ENC0], reg_q[ADDR_MSG_ENC0+1],
                           reg_q[ADDR_MSG_ENC0+2], reg_q[ADDR_MSG_ENC0+3]};
    assign EXPORT_DATA  = {reg_q[0][31:16], reg_q[3][15:0]};
    assign AVL_READDATA = (AVL_CS && AVL_READ) ? reg_q[AVL_ADDR] : 32'h0;

endmodule

// File: tb/tb_aes_avalon_interface.sv
// tb/tb_aes_avalon_interface.sv - self-checking bench for aes_avalon_interface
module tb_aes_avalon_interface;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         AVL_CS, AVL_READ, AVL_WRITE;
    logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
    logic [31:0]  AVL_WRITEDATA, AVL_READDATA;
    logic [127:0] AES_KEY, AES_MSG_ENC, AES_MSG_DEC;
    logic         AES_START, AES_DONE;
    logic [31:0]  EXPORT_DATA;

    int checks = 0;
    int errors = 0;

    // Expected software-visible register contents.
    logic [31:0] mdl [16];

    aes_avalon_interface dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .AVL_CS        (AVL_CS),
        .AVL_READ      (AVL_READ),
        .AVL_WRITE     (AVL_WRITE),
        .AVL_ADDR      (AVL_ADDR),
        .AVL_BYTE_EN   (AVL_BYTE_EN),
        .AVL_WRITEDATA (AVL_WRITEDATA),
        .AVL_READDATA  (AVL_READDATA),
        .AES_KEY       (AES_KEY),
        .AES_MSG_ENC   (AES_MSG_ENC),
        .AES_START     (AES_START),
        .AES_DONE      (AES_DONE),
        .AES_MSG_DEC   (AES_MSG_DEC),
        .EXPORT_DATA   (EXPORT_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] data);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = data[8*k +: 8];
        end
        return r;
    endfunction

    // Model of a software write; 'idle' says whether the controller is idle.
    task automatic mdl_write(input int a, input logic [3:0] be, input logic [31:0] d, input bit idle);
        if ((a < 8 && idle) || a == 12 || a == 13) mdl[a] = merge(mdl[a], be, d);
        else if (a == 14 && be[0]) mdl[14] = {31'b0, d[0]};
    endtask

    function automatic logic [127:0] words(input int base);
        return {mdl[base], mdl[base+1], mdl[base+2], mdl[base+3]};
    endfunction

    task automatic avl_write(input int a, input logic [3:0] be, input logic [31:0] d);
        @(negedge CLK);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 4'(a); AVL_BYTE_EN = be; AVL_WRITEDATA = d;
        @(posedge CLK);
        #1;
        AVL_CS = 0; AVL_WRITE = 0;
    endtask

    task automatic avl_read(input int a, output logic [31:0] d);
        @(negedge CLK);
        AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 4'(a);
        #1;
        d = AVL_READDATA;
        AVL_CS = 0; AVL_READ = 0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int a = 0; a < 16; a++) begin
            avl_read(a, d);
            chk($sformatf("%s_rd%0d", tag, a), 128'(d), 128'(mdl[a]));
        end
    endtask

    task automatic do_reset();
        RESET_N = 0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1;
        for (int a = 0; a < 16; a++) mdl[a] = '0;
    endtask

    // Start a run: START<-1, then the controller enters RUN one edge later.
    task automatic start_run(input string tag);
        avl_write(14, 4'b0001, 32'h1);
        mdl_write(14, 4'b0001, 32'h1, 1);
        chk({tag, "_start_pre"}, 128'(AES_START), 128'(0));
        @(posedge CLK);
        #1;
        chk({tag, "_start_run"}, 128'(AES_START), 128'(1));
    endtask

    // Core model: finishes 'lat' cycles later and holds its result until sampled.
    task automatic core_finish(input int lat, input logic [127:0] res);
        repeat (lat) @(posedge CLK);
        @(negedge CLK);
        AES_DONE = 1; AES_MSG_DEC = res;
        repeat (2) @(posedge CLK);
        #1;
        AES_DONE = 0;
        for (int w = 0; w < 4; w++) mdl[8+w] = res[127 - 32*w -: 32];
        mdl[15] = 1;
    endtask

    initial begin
        logic [31:0]  d;
        logic [127:0] key_a, res, key_before;
        logic [3:0]   be;
        logic [31:0]  wd;

        AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0; AVL_ADDR = 0; AVL_BYTE_EN = 0; AVL_WRITEDATA = 0;
        AES_DONE = 0; AES_MSG_DEC = '0;

        // Reset state
        do_reset();
        chk("rst_start", 128'(AES_START), 128'(0));
        chk("rst_key", AES_KEY, 128'(0));
        chk("rst_msg", AES_MSG_ENC, 128'(0));
        chk("rst_export", 128'(EXPORT_DATA), 128'(0));
        check_all("rst");

        // Partial byte-lane write
        avl_write(0, 4'b0101, 32'h12345678);
        mdl_write(0, 4'b0101, 32'h12345678, 1);
        avl_read(0, d);
        chk("be_0101", 128'(d), 128'(32'h00340078));

        // Fixed key write and read-back
        key_a = 128'h3b280014beaac269d613a16bfdc2be03;
        for (int w = 0; w < 4; w++) begin
            avl_write(w, 4'hf, key_a[127 - 32*w -: 32]);
            mdl_write(w, 4'hf, key_a[127 - 32*w -: 32], 1);
        end
        chk("key_a", AES_KEY, key_a);
        check_all("key_a");

        // Random byte-enabled writes to MSG_ENC and scratch
        for (int n = 0; n < 24; n++) begin
            int a;
            a = (n % 3 == 0) ? 12 + int'($urandom_range(0, 1)) : 4 + int'($urandom_range(0, 3));
            be = 4'($urandom);
            wd = $urandom;
            avl_write(a, be, wd);
            mdl_write(a, be, wd, 1);
        end
        chk("msg_enc", AES_MSG_ENC, words(4));
        chk("export", 128'(EXPORT_DATA), 128'({mdl[0][31:16], mdl[3][15:0]}));
        check_all("rand");

        // Read strobe gating
        @(negedge CLK);
        AVL_CS = 1; AVL_READ = 0; AVL_ADDR = 4'd0;
        #1 chk("rd_no_read", 128'(AVL_READDATA), 128'(0));
        AVL_CS = 0; AVL_READ = 1;
        #1 chk("rd_no_cs", 128'(AVL_READDATA), 128'(0));
        AVL_READ = 0;

        // First run: protected writes during RUN, result capture after 20 cycles
        start_run("run1");
        key_before = words(0);
        avl_write(0, 4'hf, 32'hffffffff);
        avl_write(8, 4'hf, 32'hffffffff);
        chk("run1_key_frozen", AES_KEY, key_before);
        avl_read(8, d);
        chk("run1_dec_ro", 128'(d), 128'(0));
        res = 128'h000102030405060708090a0b0c0d0e0f;
        core_finish(20, res);
        chk("run1_hold_start", 128'(AES_START), 128'(1));
        check_all("run1_done");

        // START<-1 again in DONE has no effect
        avl_write(14, 4'b0001, 32'h1);
        repeat (2) @(posedge CLK);
        #1 chk("run1_restart_ign", 128'(AES_START), 128'(1));
        avl_read(15, d);
        chk("run1_done_hold", 128'(d), 128'(1));

        // START<-0 returns to IDLE and clears DONE
        avl_write(14, 4'b0001, 32'h0);
        mdl_write(14, 4'b0001, 32'h0, 0);
        @(posedge CLK);
        #1 chk("run1_idle", 128'(AES_START), 128'(0));
        mdl[15] = 0;
        avl_read(15, d);
        chk("run1_done_clr", 128'(d), 128'(0));

        // Second run with new key; START dropped in the same cycle the core finishes
        key_a = 128'h000102030405060708090a0b0c0d0e0f;
        for (int w = 0; w < 4; w++) begin
            avl_write(w, 4'hf, key_a[127 - 32*w -: 32]);
            mdl_write(w, 4'hf, key_a[127 - 32*w -: 32], 1);
        end
        chk("key_b", AES_KEY, key_a);
        start_run("run2");
        repeat ($urandom_range(1, 10)) @(posedge CLK);
        res = {$urandom, $urandom, $urandom, $urandom};
        @(negedge CLK);
        AES_DONE = 1; AES_MSG_DEC = res;
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 4'd14; AVL_BYTE_EN = 4'b0001; AVL_WRITEDATA = 32'h0;
        @(posedge CLK);
        #1;
        AVL_CS = 0; AVL_WRITE = 0;
        mdl[14] = 0;
        chk("run2_capture_busy", 128'(AES_START), 128'(1));
        @(posedge CLK);
        #1 AES_DONE = 0;
        avl_read(15, d);
        chk("run2_done_one", 128'(d), 128'(1));
        chk("run2_start_done", 128'(AES_START), 128'(1));
        avl_read(15, d);
        chk("run2_done_gone", 128'(d), 128'(0));
        chk("run2_idle", 128'(AES_START), 128'(0));
        for (int w = 0; w < 4; w++) mdl[8+w] = res[127 - 32*w -: 32];
        chk("run2_key_kept", AES_KEY, key_a);
        check_all("run2");

        // AES_DONE outside RUN is ignored
        @(negedge CLK);
        AES_DONE = 1; AES_MSG_DEC = ~res;
        repeat (3) @(posedge CLK);
        #1 AES_DONE = 0;
        chk("idle_done_ign", 128'(AES_START), 128'(0));
        check_all("idle_done");

        // Reset 5 cycles into RUN: immediate abort, everything cleared
        start_run("run3");
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        #2 RESET_N = 0;
        #1;
        chk("rst_async_start", 128'(AES_START), 128'(0));
        chk("rst_async_key", AES_KEY, 128'(0));
        chk("rst_async_export", 128'(EXPORT_DATA), 128'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1;
        for (int a = 0; a < 16; a++) mdl[a] = '0;
        @(negedge CLK);
        AES_DONE = 1; AES_MSG_DEC = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge CLK);
        #1 AES_DONE = 0;
        chk("rst_late_done", 128'(AES_START), 128'(0));
        check_all("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
